// File: rtl/i2c_clk_pkg.sv
// Shared encodings and constant helpers for the I2C SCL timing controller.
package i2c_clk_pkg;

    typedef enum logic [1:0] {
        MODE_10K  = 2'd0,
        MODE_100K = 2'd1,
        MODE_400K = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STRETCH = 2'd2
    } state_e;

    // Ceiling division keeps the generated bus rate at or below nominal.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // The reserved encoding falls back to standard mode.
    function automatic mode_e decode_mode(input logic [1:0] sel);
        case (sel)
            2'd0:    return MODE_10K;
            2'd2:    return MODE_400K;
            default: return MODE_100K;
        endcase
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for the raw SCL pin; resets to the released (high) level.
module i2c_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage shift; blocking would collapse it to one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_scl_scheduler.sv
// Quarter-period SCL timing for the I2C master: rate selection, start/stop
// sequencing on period boundaries, and clock-stretch detection with timeout.
module i2c_scl_scheduler
    import i2c_clk_pkg::*;
#(
    parameter int CLK_FREQUENCY = 12000000,
    parameter int STRETCH_MAX   = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_sel,
    input  logic       start,
    input  logic       stop,
    input  logic       scl_in,
    output logic       busy,
    output logic [1:0] phase,
    output logic       phase_tick,
    output logic       scl_out,
    output logic [1:0] active_mode,
    output logic       stretch,
    output logic       stretch_timeout
);

    localparam int Q_10K  = ceil_div(CLK_FREQUENCY, 40000);
    localparam int Q_100K = ceil_div(CLK_FREQUENCY, 400000);
    localparam int Q_400K = ceil_div(CLK_FREQUENCY, 1600000);

    localparam int CW = (Q_10K > 1) ? $clog2(Q_10K) : 1;
    localparam int SW = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;

    localparam logic [CW-1:0] LAST_10K     = CW'(Q_10K - 1);
    localparam logic [CW-1:0] LAST_100K    = CW'(Q_100K - 1);
    localparam logic [CW-1:0] LAST_400K    = CW'(Q_400K - 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_MAX - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic [1:0]    phase_q, phase_d;
    logic          scl_out_q, scl_out_d;
    mode_e         mode_q, mode_d;
    logic          timeout_q, timeout_d;
    logic          stop_pend_q, stop_pend_d;
    logic [SW-1:0] stretch_cnt_q, stretch_cnt_d;

    logic          scl_s;
    logic [CW-1:0] quarter_last;
    logic          freeze;
    logic          tick;
    logic [1:0]    phase_next;

    i2c_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (scl_in),
        .q     (scl_s)
    );

    always_comb begin
        case (mode_q)
            MODE_10K:  quarter_last = LAST_10K;
            MODE_400K: quarter_last = LAST_400K;
            default:   quarter_last = LAST_100K;
        endcase
    end

    // A slave holding SCL low while we release it freezes the quarter timer.
    assign freeze     = (state_q != ST_IDLE) && (phase_q == 2'd2) && !scl_s;
    assign tick       = (state_q != ST_IDLE) && !freeze && (counter_q == quarter_last);
    assign phase_next = phase_q + 2'd1;

    // NOTE: every signal gets its default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        phase_d       = phase_q;
        scl_out_d     = scl_out_q;
        mode_d        = mode_q;
        timeout_d     = timeout_q;
        stop_pend_d   = stop_pend_q;
        stretch_cnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                scl_out_d   = 1'b1;
                phase_d     = 2'd0;
                counter_d   = '0;
                stop_pend_d = 1'b0;
                if (start) begin
                    mode_d    = decode_mode(mode_sel);
                    timeout_d = 1'b0;
                    scl_out_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end

            default: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end

                if (freeze) begin
                    state_d = ST_STRETCH;
                    if (state_q == ST_STRETCH) begin
                        if (stretch_cnt_q == STRETCH_LAST) begin
                            timeout_d   = 1'b1;
                            state_d     = ST_IDLE;
                            phase_d     = 2'd0;
                            counter_d   = '0;
                            scl_out_d   = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            stretch_cnt_d = stretch_cnt_q + SW'(1);
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                    if (tick) begin
                        counter_d = '0;
                        phase_d   = phase_next;
                        scl_out_d = phase_next[1];
                        // Rate and stop requests only take effect between full SCL periods.
                        if (phase_q == 2'd3) begin
                            mode_d = decode_mode(mode_sel);
                            if (stop_pend_q) begin
                                state_d     = ST_IDLE;
                                scl_out_d   = 1'b1;
                                stop_pend_d = 1'b0;
                            end
                        end
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            phase_q       <= 2'd0;
            scl_out_q     <= 1'b1;
            mode_q        <= MODE_100K;
            timeout_q     <= 1'b0;
            stop_pend_q   <= 1'b0;
            stretch_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            phase_q       <= phase_d;
            scl_out_q     <= scl_out_d;
            mode_q        <= mode_d;
            timeout_q     <= timeout_d;
            stop_pend_q   <= stop_pend_d;
            stretch_cnt_q <= stretch_cnt_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign phase           = phase_q;
    assign phase_tick      = tick;
    assign scl_out         = scl_out_q;
    assign active_mode     = mode_q;
    assign stretch         = freeze;
    assign stretch_timeout = timeout_q;

endmodule
